// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the clock phase meter.
//   state_t   : measurement FSM states (IDLE, MEASURE)
//   CNT_W_DEF : default counter / result width
//   CNT_MAX   : saturation value of a default-width counter
package clk_meas_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int CNT_W_DEF = 16;
  localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer plus edge detector for one asynchronous input.
// Ports:
//   clk   in  sampling clock
//   rst_n in  asynchronous active-low reset (clears every flop)
//   d     in  asynchronous input
//   rise  out one-cycle pulse on a synchronized 0->1 transition
//   fall  out one-cycle pulse on a synchronized 1->0 transition
// Latency from d to rise/fall is SYNC_STAGES+1 clk cycles.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
      r_prev <= w_s;
      // Registered pulses keep the edge outputs glitch-free for the FSM.
      r_rise <= w_s & ~r_prev;
      r_fall <= ~w_s & r_prev;
    end
  end

  assign rise = r_rise;
  assign fall = r_fall;

endmodule

// File: rtl/clk_phase_meter.sv
// Measures period, high time and ref->sft rising-edge delay of two clocks
// in units of the system clock.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   en                  measurement enable; low forces IDLE and clears state
//   sig_ref, sig_sft    asynchronous reference and phase-shifted clocks
//   period, high_time   last measured period / high time
//   phase, phase_ok     last measured delay and whether a sft rise was seen
//   meas_valid          one-cycle strobe when the results update
//   timeout             sticky, counter saturated while measuring
//   dbg                 {state, rise_ref, fall_ref, rise_sft, fall_sft}
// Handshake: meas_valid is a pure strobe with no ready; results are held
// stable until the next strobe, so a consumer may sample them any time.
module clk_phase_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_ref,
  input  logic             sig_sft,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] phase,
  output logic             phase_ok,
  output logic             meas_valid,
  output logic             timeout,
  output logic [4:0]       dbg
);

  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic w_rise_ref, w_fall_ref, w_rise_sft, w_fall_sft;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hi_cap;
  logic             r_hi_seen;
  logic [CNT_W-1:0] r_ph_cap;
  logic             r_ph_seen;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high_time;
  logic [CNT_W-1:0] r_phase;
  logic             r_phase_ok;
  logic             r_meas_valid;
  logic             r_timeout;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_ref (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sig_ref),
    .rise (w_rise_ref),
    .fall (w_fall_ref)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sft (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sig_sft),
    .rise (w_rise_sft),
    .fall (w_fall_sft)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_hi_cap     <= '0;
      r_hi_seen    <= 1'b0;
      r_ph_cap     <= '0;
      r_ph_seen    <= 1'b0;
      r_period     <= '0;
      r_high_time  <= '0;
      r_phase      <= '0;
      r_phase_ok   <= 1'b0;
      r_meas_valid <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      if (!en) begin
        // Results are deliberately kept; only the in-flight state clears.
        r_state   <= IDLE;
        r_cnt     <= '0;
        r_hi_cap  <= '0;
        r_hi_seen <= 1'b0;
        r_ph_cap  <= '0;
        r_ph_seen <= 1'b0;
        r_timeout <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_rise_ref) begin
              r_state   <= MEASURE;
              r_cnt     <= CNT_ONE;
              r_hi_cap  <= '0;
              r_hi_seen <= 1'b0;
              // A sft rise coincident with the ref rise is phase 0.
              r_ph_cap  <= '0;
              r_ph_seen <= w_rise_sft;
            end
          end
          MEASURE: begin
            if (w_rise_ref) begin
              r_period     <= r_cnt;
              r_high_time  <= r_hi_seen ? r_hi_cap : '0;
              r_phase      <= r_ph_cap;
              r_phase_ok   <= r_ph_seen;
              r_meas_valid <= 1'b1;
              r_cnt        <= CNT_ONE;
              r_hi_cap     <= '0;
              r_hi_seen    <= 1'b0;
              r_ph_cap     <= '0;
              r_ph_seen    <= w_rise_sft;
            end else if (r_cnt == CNT_SAT) begin
              r_timeout <= 1'b1;
              r_state   <= IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
              if (w_fall_ref && !r_hi_seen) begin
                r_hi_cap  <= r_cnt;
                r_hi_seen <= 1'b1;
              end
              if (w_rise_sft && !r_ph_seen) begin
                r_ph_cap  <= r_cnt;
                r_ph_seen <= 1'b1;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign period     = r_period;
  assign high_time  = r_high_time;
  assign phase      = r_phase;
  assign phase_ok   = r_phase_ok;
  assign meas_valid = r_meas_valid;
  assign timeout    = r_timeout;
  assign dbg        = {r_state, w_rise_ref, w_fall_ref, w_rise_sft, w_fall_sft};

endmodule

// File: doc/clk_phase_meter.md
# clk_phase_meter

Synthesizable measurement block for clock waveforms of the kind our generators produce. It samples a reference clock and a shifted clock with a faster system clock. It measures reference period, reference high time and the reference-to-shifted rising-edge delay, all in system-clock cycles. It sits between generated or external clocks and the checking logic, turning frequency, duty cycle and phase parameters back into numbers.

## Interface
- CNT_W, 16, width of all counters and measurement outputs
- SYNC_STAGES, 2, synchronizer flops per sampled input (minimum 2)
- clk  in  1  system sampling clock; must be faster than 2x the measured clocks
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  measurement enable; low forces IDLE
- sig_ref  in  1  reference clock (asynchronous to clk)
- sig_sft  in  1  phase-shifted clock (asynchronous to clk)
- period  out  CNT_W  clk cycles between consecutive sig_ref rising edges
- high_time  out  CNT_W  clk cycles from sig_ref rise to sig_ref fall
- phase  out  CNT_W  clk cycles from sig_ref rise to first sig_sft rise
- phase_ok  out  1  phase is valid for the last period
- meas_valid  out  1  one-cycle strobe when period/high_time/phase/phase_ok update
- timeout  out  1  sticky; set on counter saturation, cleared by en low or reset

## Operation
- Inputs pass through SYNC_STAGES flops, then a one-flop edge detector produces rise_ref, fall_ref and rise_sft, each a single-cycle pulse.
- States:
  - IDLE: wait for rise_ref, then go to MEASURE with cnt=1.
  - MEASURE: counting.
- cnt rule:
  - On the rise_ref cycle, cnt <= 1.
  - Otherwise cnt <= cnt+1, saturating at 2^CNT_W-1.
- In MEASURE:
  - On fall_ref, capture hi_cap <= cnt (first fall only).
  - On rise_sft, capture ph_cap <= cnt and set ph_seen (first rise only).
  - rise_sft on the same cycle as rise_ref captures phase 0 for the new period.
- On rise_ref in MEASURE:
  - period <= cnt; high_time <= hi_cap (0 if no fall seen); phase <= ph_cap; phase_ok <= ph_seen.
  - meas_valid pulses next cycle.
  - hi_cap and ph_seen clear for the new period. Stay in MEASURE.
- When cnt reaches saturation in MEASURE: set timeout, go to IDLE, emit no meas_valid.
- en low: go to IDLE and clear cnt, captures and timeout. Outputs hold their last values.
- Reset values: period=0, high_time=0, phase=0, phase_ok=0, meas_valid=0, timeout=0, state=IDLE.
- Reset asserted mid-measurement aborts immediately. The first result after release needs two sig_ref rises.

## Timing
- Input-to-edge-pulse latency: SYNC_STAGES+1 clk cycles. This latency is identical for both inputs, so it cancels in all measurements.
- Measurement quantization: ±1 clk cycle.
- Outputs update on the clk edge after the rise_ref pulse. meas_valid is high for exactly that one cycle.
- Minimum measurable high and low phases: 2 clk cycles each. Shorter pulses may be missed; no error is flagged.
- First meas_valid occurs one full sig_ref period after the first detected rise.
- sig_sft rising after the period ends counts in the next period. A phase shift of 360° therefore reads as phase=0.

## Structure
- Package clk_meas_pkg holds:
  - state enum {IDLE, MEASURE}
  - default CNT_W
  - saturation constant CNT_MAX
- Sub-module sync_edge_det (parameter SYNC_STAGES) is instantiated twice. Ports: clk, rst_n, d in; rise, fall out. Reset clears all flops to 0.
- Top level contains the FSM, the counter and the capture/output registers.

## Test plan
- sig_ref period 20 clk, high 8, sig_sft delayed 5 clk -> each meas_valid shows period=20, high_time=8, phase=5, phase_ok=1.
- sig_ref period 40, high 30 (75% duty), sig_sft delayed 0 -> period=40, high_time=30, phase=0, phase_ok=1.
- sig_sft held low, sig_ref period 16 -> period=16, phase_ok=0, meas_valid still pulses once per period.
- CNT_W=6, sig_ref stuck high after one rise -> timeout=1 once cnt saturates at 63, state IDLE, no meas_valid; en low then high -> timeout=0.
- rst_n pulsed low mid-period -> all outputs 0 immediately; the first meas_valid follows the second sig_ref rise after release with correct values.
- sig_sft delayed 270° of a 24-clk period (18 clk) -> phase=18 (±1); then switch period to 12 -> next complete measurement reads period=12.
